// File: rtl/add_sub_pkg.sv
// Shared types and the prefix-combine operators for the 16-bit Kogge-Stone adder/subtractor.
package add_sub_pkg;

  localparam int W      = 16;
  localparam int LEVELS = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Black cell: group (G,P) of the high span absorbs the adjacent low span.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  // Gray cell: once a group reaches bit 0 only its generate is ever needed.
  function automatic logic gray_combine(input logic g_hi, input logic p_hi, input logic g_lo);
    return g_hi | (p_hi & g_lo);
  endfunction

endpackage

// File: rtl/add_sub16_prefix_cell.sv
// One black cell of the prefix network: merges a high (G,P) group with the adjacent low group.
module prefix_cell
  import add_sub_pkg::*;
(
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  gp_t res;

  assign res = gp_combine(gp_t'({g_hi, p_hi}), gp_t'({g_lo, p_lo}));
  assign g   = res.g;
  assign p   = res.p;

endmodule

// File: rtl/add_sub16.sv
// 16-bit registered add/subtract on a 4-level Kogge-Stone carry tree; cin=1 selects a-b.
module add_sub16
  import add_sub_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] S,
  output logic         cout,
  output logic         ovf
);

  logic [W-1:0]            bb;
  logic [W-1:0]            g;
  logic [W-1:0]            p;
  logic [LEVELS:0][W-1:0]  gl;
  logic [W-1:2]            p1;
  logic [W-1:4]            p2;
  logic [W-1:8]            p3;
  logic [W-1:0]            sum;
  logic                    cout_n;
  logic                    ovf_n;

  assign bb    = b ^ {W{cin}};
  assign g     = a & bb;
  assign p     = a ^ bb;
  assign gl[0] = {g[W-1:1], g[0] | (p[0] & cin)};

  // Group P is kept only where a later black cell still reads it (groups not yet reaching bit 0).
  for (genvar col = 0; col < W; col++) begin : lvl0
    if (col < 1) begin : pass
      assign gl[1][col] = gl[0][col];
    end else if (col < 2) begin : gray
      assign gl[1][col] = gray_combine(gl[0][col], p[col], gl[0][col-1]);
    end else begin : black
      prefix_cell u_cell (
        .g_hi(gl[0][col]), .p_hi(p[col]), .g_lo(gl[0][col-1]), .p_lo(p[col-1]),
        .g(gl[1][col]), .p(p1[col])
      );
    end
  end

  for (genvar col = 0; col < W; col++) begin : lvl1
    if (col < 2) begin : pass
      assign gl[2][col] = gl[1][col];
    end else if (col < 4) begin : gray
      assign gl[2][col] = gray_combine(gl[1][col], p1[col], gl[1][col-2]);
    end else begin : black
      prefix_cell u_cell (
        .g_hi(gl[1][col]), .p_hi(p1[col]), .g_lo(gl[1][col-2]), .p_lo(p1[col-2]),
        .g(gl[2][col]), .p(p2[col])
      );
    end
  end

  for (genvar col = 0; col < W; col++) begin : lvl2
    if (col < 4) begin : pass
      assign gl[3][col] = gl[2][col];
    end else if (col < 8) begin : gray
      assign gl[3][col] = gray_combine(gl[2][col], p2[col], gl[2][col-4]);
    end else begin : black
      prefix_cell u_cell (
        .g_hi(gl[2][col]), .p_hi(p2[col]), .g_lo(gl[2][col-4]), .p_lo(p2[col-4]),
        .g(gl[3][col]), .p(p3[col])
      );
    end
  end

  for (genvar col = 0; col < W; col++) begin : lvl3
    if (col < 8) begin : pass
      assign gl[4][col] = gl[3][col];
    end else begin : gray
      assign gl[4][col] = gray_combine(gl[3][col], p3[col], gl[3][col-8]);
    end
  end

  assign sum    = p ^ {gl[LEVELS][W-2:0], cin};
  assign cout_n = gl[LEVELS][W-1];
  assign ovf_n  = (a[W-1] == bb[W-1]) & (sum[W-1] != a[W-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      S    <= sum;
      cout <= cout_n;
      ovf  <= ovf_n;
    end
  end

endmodule

// File: tb/tb_add_sub16.sv
// Scoreboard bench for add_sub16: stimulus queues expected results, a monitor checks each cycle.
module tb_add_sub16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] S;
  logic        cout;
  logic        ovf;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  add_sub16 dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
    .S(S), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string nm, input logic [15:0] got_s, input logic got_c,
                              input logic got_o, input exp_t e);
    tests_run++;
    if ({got_s, got_c, got_o} !== {e.s, e.c, e.o}) begin
      tests_failed++;
      $display("[TB] FAIL %s: got S=%h cout=%b ovf=%b, expected S=%h cout=%b ovf=%b",
               nm, got_s, got_c, got_o, e.s, e.c, e.o);
    end
  endtask

  // Drive one operation on the falling edge; its result is due after the next rising edge.
  task automatic apply_stimulus(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                                input logic [15:0] es, input logic ec, input logic eo,
                                input string nm);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    a   = va;
    b   = vb;
    cin = vc;
    e.s = es; e.c = ec; e.o = eo;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic reset_cycle(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    exp_t z;
    z = '0;
    @(negedge clk);
    a   = va;
    b   = vb;
    cin = vc;
    rst = 1'b1;
    #1;
    check_output("reset_pulse_async", S, cout, ovf, z);
    exp_q.push_back(z);
    name_q.push_back("reset_pulse_edge");
  endtask

  always @(posedge clk) begin
    exp_t  e;
    string nm;
    #1;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check_output(nm, S, cout, ovf, e);
    end
  end

  initial begin
    exp_t        z;
    logic [15:0] ra, rb, rbb, rs;
    logic        rc, rco, ro;
    logic [16:0] full;
    z   = '0;
    rst = 1'b1;
    a   = 16'h0000;
    b   = 16'h0000;
    cin = 1'b0;
    #2;
    check_output("reset_initial", S, cout, ovf, z);

    apply_stimulus(16'h0069, 16'h0069, 1'b0, 16'h00d2, 1'b0, 1'b0, "pre_reset_add");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_output("reset_async_midcycle", S, cout, ovf, z);

    apply_stimulus(16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0, "add_0000_0001");
    apply_stimulus(16'h0069, 16'h0069, 1'b0, 16'h00d2, 1'b0, 1'b0, "add_0069_0069");
    apply_stimulus(16'h0100, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b0, "add_0100_0000");
    apply_stimulus(16'h0110, 16'h1001, 1'b0, 16'h1111, 1'b0, 1'b0, "add_0110_1001");
    apply_stimulus(16'h1010, 16'h0101, 1'b0, 16'h1111, 1'b0, 1'b0, "add_1010_0101");
    apply_stimulus(16'h55aa, 16'haa55, 1'b0, 16'hffff, 1'b0, 1'b0, "add_55aa_aa55");
    apply_stimulus(16'hffff, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ripple_ffff_0001");
    apply_stimulus(16'h0000, 16'h0001, 1'b1, 16'hffff, 1'b0, 1'b0, "sub_0000_0001");
    apply_stimulus(16'h0069, 16'h0069, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_0069_0069");
    apply_stimulus(16'h0100, 16'h0000, 1'b1, 16'h0100, 1'b1, 1'b0, "sub_0100_0000");
    apply_stimulus(16'h0110, 16'h1001, 1'b1, 16'hf10f, 1'b0, 1'b0, "sub_0110_1001");
    apply_stimulus(16'hffff, 16'h0001, 1'b1, 16'hfffe, 1'b1, 1'b0, "sub_ffff_0001");
    apply_stimulus(16'h55aa, 16'haa55, 1'b1, 16'hab55, 1'b0, 1'b1, "sub_55aa_aa55");
    apply_stimulus(16'h1010, 16'h0101, 1'b1, 16'h0f0f, 1'b1, 1'b0, "sub_1010_0101");
    apply_stimulus(16'h7fff, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_add_7fff_0001");
    apply_stimulus(16'h8000, 16'h0001, 1'b1, 16'h7fff, 1'b1, 1'b1, "ovf_sub_8000_0001");

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom());
      rb = 16'($urandom());
      rc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        reset_cycle(ra, rb, rc);
      end else begin
        rbb  = rb ^ {16{rc}};
        full = {1'b0, ra} + {1'b0, rbb} + {16'h0000, rc};
        rs   = full[15:0];
        rco  = full[16];
        ro   = (ra[15] == rbb[15]) && (rs[15] != ra[15]);
        apply_stimulus(ra, rb, rc, rs, rco, ro, "random_stream");
      end
    end

    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: %0d results still pending, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
